// File: rtl/traffic_phase_scheduler.sv
// Two-direction junction sequencer: one 8-phase FSM drives both lamp sets, BCD countdown displays.
// Latency: every output is registered and reflects EN/TICK/CFG/PED inputs one CLK after sampling.
// No backpressure: TICK strobes are consumed every cycle; optional PED_CROSS_EN macro adds PED_REQ.
module traffic_phase_scheduler #(
    parameter logic [7:0] D_AG = 8'd40,
    parameter logic [7:0] D_AY = 8'd5,
    parameter logic [7:0] D_AL = 8'd15,
    parameter logic [7:0] D_BG = 8'd30,
    parameter logic [7:0] D_BY = 8'd5,
    parameter logic [7:0] D_BL = 8'd15
`ifdef PED_CROSS_EN
    , parameter logic [7:0] PED_MIN = 8'd5
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       TICK,
`ifdef PED_CROSS_EN
    input  logic       PED_REQ,
`endif
    input  logic       CFG_WE,
    input  logic [2:0] CFG_ADDR,
    input  logic [7:0] CFG_DATA,
    output logic [3:0] LAMPA,
    output logic [3:0] LAMPB,
    output logic [7:0] ACOUNT,
    output logic [7:0] BCOUNT,
    output logic [2:0] PHASE
);

    localparam logic [2:0] P_AG  = 3'd0;
    localparam logic [2:0] P_AY1 = 3'd1;
    localparam logic [2:0] P_AL  = 3'd2;
    localparam logic [2:0] P_AY2 = 3'd3;
    localparam logic [2:0] P_BG  = 3'd4;
    localparam logic [2:0] P_BY1 = 3'd5;
    localparam logic [2:0] P_BL  = 3'd6;
    localparam logic [2:0] P_BY2 = 3'd7;

    localparam logic [3:0] L_LEFT   = 4'b0001;
    localparam logic [3:0] L_GREEN  = 4'b0010;
    localparam logic [3:0] L_YELLOW = 4'b0100;
    localparam logic [3:0] L_RED    = 4'b1000;

    // Config regs indexed by CFG_ADDR: 0=AG 1=AY 2=AL 3=BG 4=BY 5=BL
    logic [7:0] cfg [0:5];

    logic       run;
    logic [2:0] phase;
    logic [7:0] pc;
    logic [8:0] rc;

    logic       nxt_run;
    logic [2:0] nxt_phase;
    logic [7:0] nxt_pc;
    logic [8:0] nxt_rc;
    logic [8:0] a_red_span;
    logic [8:0] b_red_span;
    logic [3:0] lamp_a;
    logic [3:0] lamp_b;
    logic [7:0] disp_a;
    logic [7:0] disp_b;

    // Duration of a phase; both yellow phases of a direction share one register
    function automatic logic [7:0] dur(input logic [2:0] p,
                                       input logic [7:0] ag, input logic [7:0] ay,
                                       input logic [7:0] al, input logic [7:0] bg,
                                       input logic [7:0] by, input logic [7:0] bl);
        case (p)
            P_AG:          dur = ag;
            P_AY1, P_AY2:  dur = ay;
            P_AL:          dur = al;
            P_BG:          dur = bg;
            P_BY1, P_BY2:  dur = by;
            default:       dur = bl;
        endcase
    endfunction

    // Saturate to 99 then split into {tens,units} by repeated subtraction (at most 9 steps)
    function automatic logic [7:0] to_bcd(input logic [8:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = (v > 9'd99) ? 7'd99 : v[6:0];
        t = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        to_bcd = {t, r[3:0]};
    endfunction

    assign a_red_span = {1'b0, cfg[3]} + {1'b0, cfg[4]} + {1'b0, cfg[5]} + {1'b0, cfg[4]};
    assign b_red_span = {1'b0, cfg[0]} + {1'b0, cfg[1]} + {1'b0, cfg[2]} + {1'b0, cfg[1]};

    // Next FSM state: EN-low beats everything, pedestrian truncation beats TICK
    always_comb begin
        nxt_run   = run;
        nxt_phase = phase;
        nxt_pc    = pc;
        nxt_rc    = rc;
        if (!EN) begin
            nxt_run   = 1'b0;
            nxt_phase = P_AG;
            nxt_pc    = 8'd0;
            nxt_rc    = 9'd0;
        end else if (!run) begin
            nxt_run   = 1'b1;
            nxt_phase = P_AG;
            nxt_pc    = cfg[0];
            nxt_rc    = b_red_span;
        end else
`ifdef PED_CROSS_EN
        if (PED_REQ && (phase == P_AG || phase == P_BG) && pc > PED_MIN) begin
            nxt_pc = PED_MIN;
            nxt_rc = rc - {1'b0, pc - PED_MIN};
        end else
`endif
        if (TICK) begin
            if (pc > 8'd1) begin
                nxt_pc = pc - 8'd1;
                nxt_rc = (rc != 9'd0) ? rc - 9'd1 : 9'd0;
            end else begin
                nxt_phase = phase + 3'd1;
                nxt_pc    = dur(phase + 3'd1, cfg[0], cfg[1], cfg[2], cfg[3], cfg[4], cfg[5]);
                if (phase + 3'd1 == P_BG)
                    nxt_rc = a_red_span;
                else if (phase + 3'd1 == P_AG)
                    nxt_rc = b_red_span;
                else
                    nxt_rc = (rc != 9'd0) ? rc - 9'd1 : 9'd0;
            end
        end
    end

    // Lamp and display values derived from the next state so they register alongside it
    always_comb begin
        lamp_a = L_RED;
        lamp_b = L_RED;
        disp_a = 8'h00;
        disp_b = 8'h00;
        if (nxt_run) begin
            case (nxt_phase)
                P_AG:          lamp_a = L_GREEN;
                P_AY1, P_AY2:  lamp_a = L_YELLOW;
                P_AL:          lamp_a = L_LEFT;
                P_BG:          lamp_b = L_GREEN;
                P_BY1, P_BY2:  lamp_b = L_YELLOW;
                default:       lamp_b = L_LEFT;
            endcase
            if (nxt_phase[2]) begin
                disp_a = to_bcd(nxt_rc);
                disp_b = to_bcd({1'b0, nxt_pc});
            end else begin
                disp_a = to_bcd({1'b0, nxt_pc});
                disp_b = to_bcd(nxt_rc);
            end
        end
    end

    // Config register file; out-of-range data or reserved addresses are dropped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfg[0] <= D_AG;
            cfg[1] <= D_AY;
            cfg[2] <= D_AL;
            cfg[3] <= D_BG;
            cfg[4] <= D_BY;
            cfg[5] <= D_BL;
        end else if (CFG_WE && CFG_DATA >= 8'd1 && CFG_DATA <= 8'd99 && CFG_ADDR <= 3'd5) begin
            cfg[CFG_ADDR] <= CFG_DATA;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run    <= 1'b0;
            phase  <= P_AG;
            pc     <= 8'd0;
            rc     <= 9'd0;
            LAMPA  <= L_RED;
            LAMPB  <= L_RED;
            ACOUNT <= 8'h00;
            BCOUNT <= 8'h00;
            PHASE  <= 3'd0;
        end else begin
            run    <= nxt_run;
            phase  <= nxt_phase;
            pc     <= nxt_pc;
            rc     <= nxt_rc;
            LAMPA  <= lamp_a;
            LAMPB  <= lamp_b;
            ACOUNT <= disp_a;
            BCOUNT <= disp_b;
            PHASE  <= nxt_run ? nxt_phase : 3'd0;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with hand-computed lamp/BCD expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge after.
// No backpressure on the DUT; every scenario runs for a fixed number of cycles.
module tb_traffic_phase_scheduler;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       TICK;
`ifdef PED_CROSS_EN
    logic       PED_REQ;
`endif
    logic       CFG_WE;
    logic [2:0] CFG_ADDR;
    logic [7:0] CFG_DATA;
    logic [3:0] LAMPA;
    logic [3:0] LAMPB;
    logic [7:0] ACOUNT;
    logic [7:0] BCOUNT;
    logic [2:0] PHASE;

    int total;
    int bad;

    traffic_phase_scheduler dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .TICK     (TICK),
`ifdef PED_CROSS_EN
        .PED_REQ  (PED_REQ),
`endif
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_DATA (CFG_DATA),
        .LAMPA    (LAMPA),
        .LAMPB    (LAMPB),
        .ACOUNT   (ACOUNT),
        .BCOUNT   (BCOUNT),
        .PHASE    (PHASE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // n TICK strobes, each one cycle high then one cycle low
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK) TICK = 1'b1;
            @(negedge CLK) TICK = 1'b0;
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        CFG_WE = 1'b1; CFG_ADDR = a; CFG_DATA = d;
        @(negedge CLK);
        CFG_WE = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; EN = 1'b0; TICK = 1'b0; CFG_WE = 1'b0; CFG_ADDR = 3'd0; CFG_DATA = 8'd0;
`ifdef PED_CROSS_EN
        PED_REQ = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if ({LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE} !== {4'h8, 4'h8, 8'h00, 8'h00, 3'd0}) begin
            bad++;
            $display("FAIL reset: lamps=%h/%h counts=%h/%h phase=%0d required 8/8 00/00 0",
                     LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE);
        end
        // TICK while disabled must not start anything
        ticks(2);
        total++;
        if ({LAMPA, ACOUNT, PHASE} !== {4'h8, 8'h00, 3'd0}) begin
            bad++;
            $display("FAIL tick_while_off: lampa=%h acount=%h phase=%0d required 8 00 0",
                     LAMPA, ACOUNT, PHASE);
        end
    endtask

    task automatic test_enable;
        @(negedge CLK) EN = 1'b1;
        @(negedge CLK);
        total++;
        if ({LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE} !== {4'h2, 4'h8, 8'h40, 8'h65, 3'd0}) begin
            bad++;
            $display("FAIL enable_first: lamps=%h/%h counts=%h/%h phase=%0d required 2/8 40/65 0",
                     LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE);
        end
        // counts must hold without a TICK
        repeat (3) @(negedge CLK);
        total++;
        if ({ACOUNT, BCOUNT} !== {8'h40, 8'h65}) begin
            bad++;
            $display("FAIL hold_no_tick: counts=%h/%h required 40/65", ACOUNT, BCOUNT);
        end
    endtask

    task automatic test_full_cycle;
        int         dw [8] = '{40, 5, 15, 5, 30, 5, 15, 5};
        logic [3:0] la [8] = '{4'h4, 4'h1, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h2};
        logic [3:0] lb [8] = '{4'h8, 4'h8, 4'h8, 4'h2, 4'h4, 4'h1, 4'h4, 4'h8};
        logic [7:0] ea [8] = '{8'h05, 8'h15, 8'h05, 8'h55, 8'h25, 8'h20, 8'h05, 8'h40};
        logic [7:0] eb [8] = '{8'h25, 8'h20, 8'h05, 8'h30, 8'h05, 8'h15, 8'h05, 8'h65};
        for (int i = 0; i < 8; i++) begin
            ticks(dw[i]);
            total++;
            if ({PHASE, LAMPA, LAMPB, ACOUNT, BCOUNT} !== {3'(i + 1), la[i], lb[i], ea[i], eb[i]}) begin
                bad++;
                $display("FAIL full_cycle_%0d: phase=%0d lamps=%h/%h counts=%h/%h required %0d %h/%h %h/%h",
                         i, PHASE, LAMPA, LAMPB, ACOUNT, BCOUNT, (i + 1) % 8, la[i], lb[i], ea[i], eb[i]);
            end
        end
    endtask

    task automatic test_tick_decrement;
        ticks(1);
        total++;
        if ({ACOUNT, BCOUNT, PHASE} !== {8'h39, 8'h64, 3'd0}) begin
            bad++;
            $display("FAIL dec_one: counts=%h/%h phase=%0d required 39/64 0", ACOUNT, BCOUNT, PHASE);
        end
        ticks(38);
        total++;
        if ({LAMPA, ACOUNT, BCOUNT, PHASE} !== {4'h2, 8'h01, 8'h26, 3'd0}) begin
            bad++;
            $display("FAIL dec_last: lampa=%h counts=%h/%h phase=%0d required 2 01/26 0",
                     LAMPA, ACOUNT, BCOUNT, PHASE);
        end
        ticks(6);
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd2, 8'h15, 8'h20}) begin
            bad++;
            $display("FAIL reach_al: phase=%0d counts=%h/%h required 2 15/20", PHASE, ACOUNT, BCOUNT);
        end
    endtask

    task automatic test_cfg_write;
        cfg_write(3'd0, 8'd20);
        cfg_write(3'd1, 8'd0);
        cfg_write(3'd2, 8'd100);
        cfg_write(3'd7, 8'd10);
        total++;
        if ({ACOUNT, BCOUNT, PHASE} !== {8'h15, 8'h20, 3'd2}) begin
            bad++;
            $display("FAIL write_no_disturb: counts=%h/%h phase=%0d required 15/20 2", ACOUNT, BCOUNT, PHASE);
        end
        ticks(20);
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd4, 8'h55, 8'h30}) begin
            bad++;
            $display("FAIL write_bg_entry: phase=%0d counts=%h/%h required 4 55/30", PHASE, ACOUNT, BCOUNT);
        end
        ticks(55);
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd0, 8'h20, 8'h45}) begin
            bad++;
            $display("FAIL new_ag: phase=%0d counts=%h/%h required 0 20/45", PHASE, ACOUNT, BCOUNT);
        end
        ticks(20);
        total++;
        if ({PHASE, ACOUNT} !== {3'd1, 8'h05}) begin
            bad++;
            $display("FAIL ay_kept: phase=%0d acount=%h required 1 05", PHASE, ACOUNT);
        end
        ticks(5);
        total++;
        if ({PHASE, ACOUNT} !== {3'd2, 8'h15}) begin
            bad++;
            $display("FAIL al_kept: phase=%0d acount=%h required 2 15", PHASE, ACOUNT);
        end
    endtask

    task automatic test_en_drop;
        ticks(50);
        total++;
        if ({PHASE, LAMPB, ACOUNT, BCOUNT} !== {3'd5, 4'h4, 8'h25, 8'h05}) begin
            bad++;
            $display("FAIL reach_by1: phase=%0d lampb=%h counts=%h/%h required 5 4 25/05",
                     PHASE, LAMPB, ACOUNT, BCOUNT);
        end
        // EN falls together with a TICK: EN must win
        @(negedge CLK);
        EN = 1'b0; TICK = 1'b1;
        @(negedge CLK);
        TICK = 1'b0; EN = 1'b1;
        total++;
        if ({LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE} !== {4'h8, 4'h8, 8'h00, 8'h00, 3'd0}) begin
            bad++;
            $display("FAIL en_drop: lamps=%h/%h counts=%h/%h phase=%0d required 8/8 00/00 0",
                     LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE);
        end
        @(negedge CLK);
        total++;
        if ({LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE} !== {4'h2, 4'h8, 8'h20, 8'h45, 3'd0}) begin
            bad++;
            $display("FAIL en_restart: lamps=%h/%h counts=%h/%h phase=%0d required 2/8 20/45 0",
                     LAMPA, LAMPB, ACOUNT, BCOUNT, PHASE);
        end
    endtask

    task automatic test_saturation;
        cfg_write(3'd3, 8'd99);
        cfg_write(3'd4, 8'd99);
        cfg_write(3'd5, 8'd99);
        ticks(45);
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd4, 8'h99, 8'h99}) begin
            bad++;
            $display("FAIL sat_entry: phase=%0d counts=%h/%h required 4 99/99", PHASE, ACOUNT, BCOUNT);
        end
        ticks(99 + 99 + 98);
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd6, 8'h99, 8'h01}) begin
            bad++;
            $display("FAIL sat_rc100: phase=%0d counts=%h/%h required 6 99/01", PHASE, ACOUNT, BCOUNT);
        end
        ticks(1);
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd7, 8'h99, 8'h99}) begin
            bad++;
            $display("FAIL sat_rc99: phase=%0d counts=%h/%h required 7 99/99", PHASE, ACOUNT, BCOUNT);
        end
        ticks(1);
        total++;
        if ({ACOUNT, BCOUNT} !== {8'h98, 8'h98}) begin
            bad++;
            $display("FAIL sat_release: counts=%h/%h required 98/98", ACOUNT, BCOUNT);
        end
    endtask

`ifdef PED_CROSS_EN
    task automatic test_ped;
        cfg_write(3'd0, 8'd40);
        @(negedge CLK) EN = 1'b0;
        @(negedge CLK) EN = 1'b1;
        @(negedge CLK);
        ticks(10);
        @(negedge CLK) PED_REQ = 1'b1;
        @(negedge CLK) PED_REQ = 1'b0;
        total++;
        if ({ACOUNT, BCOUNT} !== {8'h05, 8'h30}) begin
            bad++;
            $display("FAIL ped_ag: counts=%h/%h required 05/30", ACOUNT, BCOUNT);
        end
        ticks(10);
        @(negedge CLK) PED_REQ = 1'b1;
        @(negedge CLK) PED_REQ = 1'b0;
        total++;
        if ({PHASE, ACOUNT, BCOUNT} !== {3'd2, 8'h15, 8'h20}) begin
            bad++;
            $display("FAIL ped_al_ignored: phase=%0d counts=%h/%h required 2 15/20", PHASE, ACOUNT, BCOUNT);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_enable();
        test_full_cycle();
        test_tick_decrement();
        test_cfg_write();
        test_en_drop();
        test_saturation();
`ifdef PED_CROSS_EN
        test_ped();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
